// File: rtl/cr_axi4s_ob_arb.sv
// Frame-aware round-robin arbiter: N FIFO-style sources onto one AXI4-stream master.
// A grant is held from a frame's first beat through its tlast beat; the output stage is registered.
module cr_axi4s_ob_arb #(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_SRC-1:0]          src_empty,
  input  logic [N_SRC*DATA_W-1:0]   src_data,
  input  logic [N_SRC-1:0]          src_last,
  output logic [N_SRC-1:0]          src_rd,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [$clog2(N_SRC)-1:0]  out_src,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic [31:0]               frame_cnt
);

  localparam int IW = $clog2(N_SRC);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BEATS);
  localparam logic [BW-1:0] BEAT_PRE = BW'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [IW-1:0]     grant_q;
  logic [IW-1:0]     grant_d;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     idx;
  logic              found;
  logic [BW-1:0]     beat_cnt;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              out_free;
  logic              pop;
  logic              last_pop;

  // Round-robin scan: first non-empty source starting one past the last winner.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr;
    idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = IW'((int'(rr_ptr) + k) % N_SRC);
      if (!found && !src_empty[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Head-of-FIFO mux for the granted source.
  always_comb begin
    head_data = '0;
    head_last = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == IW'(i)) begin
        head_data = src_data[i*DATA_W +: DATA_W];
        head_last = src_last[i];
      end
    end
  end

  // Pop when locked, the granted source has a beat and the output slot is free.
  always_comb begin
    out_free = !out_valid || out_ready;
    pop      = (state_q == LOCK) && !src_empty[grant_q] && out_free;
    last_pop = pop && head_last;
    src_rd   = '0;
    if (pop) begin
      src_rd[grant_q] = 1'b1;
    end
  end

  // Next-state: lock onto a winner from IDLE, release after the tlast pop.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCK;
          grant_d = pick;
        end
      end
      LOCK: begin
        if (last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Round-robin pointer, frame counter, per-frame beat counter and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= IW'(N_SRC - 1);
      frame_cnt <= '0;
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= pop && !head_last && (beat_cnt == BEAT_PRE);
      if (last_pop) begin
        rr_ptr    <= grant_q;
        frame_cnt <= frame_cnt + 32'd1;
      end
      if (state_q == IDLE && found) begin
        beat_cnt <= '0;
      end else if (pop && beat_cnt != BEAT_MAX) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Registered output stage; holds stable while stalled by out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= head_data;
      out_last  <= head_last;
      out_src   <= grant_q;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
